// File: rtl/timer_ctrl_master.sv
// Avalon-MM master sequencing the interval timer slave: start/stop, IRQ service, optional counter snapshot.
// Optional feature: define TIMER_CTRL_MASTER_SNAP_EN to build the snapshot path (snap_req, snap_value, snap_valid).
module timer_ctrl_master #(
    parameter int TICK_W    = 32,
    parameter bit CONT_MODE = 1'b1,
    parameter bit ITO_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic              snap_req,
    input  logic [31:0]       period_in,
    output logic              running,
    output logic              busy,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    localparam logic [15:0] CTL_VAL  = {12'h000, 2'b01, CONT_MODE, ITO_EN};
    localparam logic [15:0] STOP_VAL = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_STOP, S_ACK
`ifdef TIMER_CTRL_MASTER_SNAP_EN
        , S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                start_p_q, start_p_d, stop_p_q, stop_p_d, snap_p_q, snap_p_d;
    logic                disp_start, disp_stop, disp_snap;
    logic [31:0]         period_q;
    logic                cs_q, cs_d, wn_q, wn_d;
    logic [2:0]          addr_q, addr_d;
    logic [15:0]         wd_q, wd_d;
    logic                running_q, running_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                tpulse_q, tpulse_d;

    always_comb begin
        state_d    = state_q;
        disp_start = 1'b0;
        disp_stop  = 1'b0;
        disp_snap  = 1'b0;
        running_d  = running_q;
        case (state_q)
            S_IDLE: begin
                if (stop_p_q) begin
                    state_d   = S_WR_STOP;
                    disp_stop = 1'b1;
                end else if (start_p_q) begin
                    state_d    = S_WR_PL;
                    disp_start = 1'b1;
                end else if (timer_irq) begin
                    state_d = S_ACK;
                end else if (snap_p_q) begin
`ifdef TIMER_CTRL_MASTER_SNAP_EN
                    state_d = S_SNAP_WR;
`endif
                    disp_snap = 1'b1;
                end
            end
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_WR_CTL;
            S_WR_CTL: begin
                state_d   = S_IDLE;
                running_d = 1'b1;
            end
            S_WR_STOP: begin
                state_d   = S_IDLE;
                running_d = 1'b0;
            end
            S_ACK:     state_d = S_IDLE;
`ifdef TIMER_CTRL_MASTER_SNAP_EN
            S_SNAP_WR:  state_d = S_SNAP_RL;
            S_SNAP_RL:  state_d = S_SNAP_RH;
            S_SNAP_RH:  state_d = S_SNAP_CAP;
            S_SNAP_CAP: state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each access is visible while its state is current.
    always_comb begin
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        addr_d   = 3'd0;
        wd_d     = 16'h0000;
        tick_d   = tick_q;
        tpulse_d = 1'b0;
        case (state_d)
            S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_q[15:0];  end
            S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_q[31:16]; end
            S_WR_CTL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CTL_VAL;         end
            S_WR_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = STOP_VAL;        end
            S_ACK: begin
                cs_d     = 1'b1;
                wn_d     = 1'b0;
                tick_d   = tick_q + TICK_W'(1);
                tpulse_d = 1'b1;
            end
`ifdef TIMER_CTRL_MASTER_SNAP_EN
            S_SNAP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
            S_SNAP_RL: begin cs_d = 1'b1; addr_d = 3'd4; end
            S_SNAP_RH: begin cs_d = 1'b1; addr_d = 3'd5; end
`endif
            default: ;
        endcase
    end

    // Stop cancels any pending start, including one arriving in the same cycle.
    assign start_p_d = ((start_p_q & ~disp_start) | start_req) & ~stop_req;
    assign stop_p_d  = (stop_p_q & ~disp_stop) | stop_req;
`ifdef TIMER_CTRL_MASTER_SNAP_EN
    assign snap_p_d  = (snap_p_q & ~disp_snap) | snap_req;
`else
    assign snap_p_d  = 1'b0;
    logic unused_snap;
    assign unused_snap = snap_req ^ disp_snap ^ snap_p_q ^ (^avm_readdata);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            start_p_q <= 1'b0;
            stop_p_q  <= 1'b0;
            snap_p_q  <= 1'b0;
            period_q  <= '0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= 3'd0;
            wd_q      <= 16'h0000;
            running_q <= 1'b0;
            tick_q    <= '0;
            tpulse_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_p_q <= start_p_d;
            stop_p_q  <= stop_p_d;
            snap_p_q  <= snap_p_d;
            if (start_req && !stop_req) period_q <= period_in;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            tpulse_q  <= tpulse_d;
        end
    end

`ifdef TIMER_CTRL_MASTER_SNAP_EN
    logic [15:0] snap_lo_q;
    logic [31:0] snap_value_q;
    logic        snap_valid_q;

    // Read data arrives one cycle after its address: low half during SNAP_RH, high half during SNAP_CAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo_q    <= 16'h0000;
            snap_value_q <= 32'h0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= (state_q == S_SNAP_CAP);
            if (state_q == S_SNAP_RH)  snap_lo_q    <= avm_readdata;
            if (state_q == S_SNAP_CAP) snap_value_q <= {avm_readdata, snap_lo_q};
        end
    end

    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
`else
    assign snap_value = 32'h0;
    assign snap_valid = 1'b0;
`endif

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wd_q;
    assign running        = running_q;
    assign busy           = (state_q != S_IDLE);
    assign tick_count     = tick_q;
    assign tick_pulse     = tpulse_q;

endmodule
